// File: rtl/mem_bus_arbiter.sv
// Arbitrates one Wishbone-classic memory bus between the fetch and data ports, data first.
// Optional bus watchdog is compiled in with `define BUS_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_stallreq,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_stallreq,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_timeout
);

  typedef enum logic [2:0] {
    IDLE, DATA_BUSY, INST_BUSY, DATA_HOLD, INST_HOLD, FLUSH_DRAIN
  } state_t;

  state_t      state_reg, state_next;
  logic        bus_cyc_reg, bus_cyc_next;
  logic        bus_stb_reg, bus_stb_next;
  logic        bus_we_reg, bus_we_next;
  logic [3:0]  bus_sel_reg, bus_sel_next;
  logic [31:0] bus_addr_reg, bus_addr_next;
  logic [31:0] bus_wdata_reg, bus_wdata_next;
  logic [31:0] inst_rdata_reg, inst_rdata_next;
  logic [31:0] data_rdata_reg, data_rdata_next;

  logic        ack_eff;
  logic [31:0] rdata_eff;
  logic        timeout_hit;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             bus_timeout_reg;
  logic             busy;

  assign busy        = (state_reg == DATA_BUSY) || (state_reg == INST_BUSY) ||
                       (state_reg == FLUSH_DRAIN);
  assign timeout_hit = busy && !bus_ack && (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  // Restart the count on every ack and on every entry into a waiting state.
  always_comb begin
    tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
    if (!busy || bus_ack || (state_next != state_reg))
      tmo_cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_reg     <= '0;
      bus_timeout_reg <= 1'b0;
    end else begin
      tmo_cnt_reg     <= tmo_cnt_next;
      bus_timeout_reg <= timeout_hit;
    end
  end

  assign bus_timeout = bus_timeout_reg;
`else
  // Without the watchdog a transaction waits for its ack indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign bus_timeout = 1'b0;
`endif

  assign ack_eff   = bus_ack || timeout_hit;
  assign rdata_eff = timeout_hit ? 32'h0 : bus_rdata;

  always_comb begin
    state_next      = state_reg;
    bus_cyc_next    = bus_cyc_reg;
    bus_stb_next    = bus_stb_reg;
    bus_we_next     = bus_we_reg;
    bus_sel_next    = bus_sel_reg;
    bus_addr_next   = bus_addr_reg;
    bus_wdata_next  = bus_wdata_reg;
    inst_rdata_next = inst_rdata_reg;
    data_rdata_next = data_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (!flush && data_req) begin
          bus_cyc_next   = 1'b1;
          bus_stb_next   = 1'b1;
          bus_we_next    = data_we;
          bus_sel_next   = data_sel;
          bus_addr_next  = data_addr;
          bus_wdata_next = data_wdata;
          state_next     = DATA_BUSY;
        end else if (!flush && inst_req) begin
          bus_cyc_next   = 1'b1;
          bus_stb_next   = 1'b1;
          bus_we_next    = 1'b0;
          bus_sel_next   = 4'hF;
          bus_addr_next  = inst_addr;
          bus_wdata_next = 32'h0;
          state_next     = INST_BUSY;
        end
      end
      DATA_BUSY: begin
        // A started load/store always completes, even across a flush.
        if (ack_eff) begin
          data_rdata_next = rdata_eff;
          state_next      = stall[4] ? DATA_HOLD : IDLE;
        end
      end
      INST_BUSY: begin
        if (ack_eff) begin
          if (flush) begin
            state_next = IDLE;
          end else begin
            inst_rdata_next = rdata_eff;
            state_next      = stall[1] ? INST_HOLD : IDLE;
          end
        end else if (flush) begin
          state_next = FLUSH_DRAIN;
        end
      end
      FLUSH_DRAIN: begin
        if (ack_eff)
          state_next = IDLE;
      end
      DATA_HOLD: begin
        if (!stall[4] || flush)
          state_next = IDLE;
      end
      INST_HOLD: begin
        if (!stall[1] || flush)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (((state_reg == DATA_BUSY) || (state_reg == INST_BUSY) ||
         (state_reg == FLUSH_DRAIN)) && ack_eff) begin
      bus_cyc_next = 1'b0;
      bus_stb_next = 1'b0;
      bus_we_next  = 1'b0;
      bus_sel_next = 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      bus_cyc_reg    <= 1'b0;
      bus_stb_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_sel_reg    <= 4'h0;
      bus_addr_reg   <= 32'h0;
      bus_wdata_reg  <= 32'h0;
      inst_rdata_reg <= 32'h0;
      data_rdata_reg <= 32'h0;
    end else begin
      state_reg      <= state_next;
      bus_cyc_reg    <= bus_cyc_next;
      bus_stb_reg    <= bus_stb_next;
      bus_we_reg     <= bus_we_next;
      bus_sel_reg    <= bus_sel_next;
      bus_addr_reg   <= bus_addr_next;
      bus_wdata_reg  <= bus_wdata_next;
      inst_rdata_reg <= inst_rdata_next;
      data_rdata_reg <= data_rdata_next;
    end
  end

  assign bus_cyc   = bus_cyc_reg;
  assign bus_stb   = bus_stb_reg;
  assign bus_we    = bus_we_reg;
  assign bus_sel   = bus_sel_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;

  // The ack cycle forwards bus data so the pipeline can advance without an extra cycle.
  assign data_rdata = ((state_reg == DATA_BUSY) && ack_eff) ? rdata_eff : data_rdata_reg;
  assign inst_rdata = ((state_reg == INST_BUSY) && ack_eff && !flush) ? rdata_eff
                                                                       : inst_rdata_reg;

  assign data_stallreq = data_req && !((state_reg == DATA_BUSY) && ack_eff) &&
                         (state_reg != DATA_HOLD);

  assign inst_stallreq = !flush &&
                         ((inst_req && !((state_reg == INST_BUSY) && ack_eff) &&
                           (state_reg != INST_HOLD)) ||
                          (state_reg == DATA_BUSY) || (state_reg == FLUSH_DRAIN));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: cycle table plus hand-written hold/timeout sequences.
// Timeout sequence is exercised only when BUS_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_stallreq;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_stallreq;
  logic        bus_cyc, bus_stb, bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_timeout;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_stallreq(inst_stallreq),
    .data_req(data_req), .data_we(data_we), .data_sel(data_sel),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_stallreq(data_stallreq),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  // ctl = {rst, flush, stall[4], stall[1], inst_req, data_req, bus_ack}
  // eflags = {bus_cyc, bus_stb, bus_we, inst_stallreq, data_stallreq}
  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic [31:0] iaddr;
    logic        dwe;
    logic [3:0]  dsel;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] brdata;
    logic [4:0]  eflags;
    logic [3:0]  esel;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [31:0] eirdata;
    logic [31:0] edrdata;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] I0 = 32'h8000_0000;
  localparam logic [31:0] I1 = 32'h8000_0004;
  localparam logic [31:0] D0 = 32'h8000_1000;
  localparam logic [31:0] D1 = 32'h8000_2000;
  localparam logic [31:0] I2 = 32'h8000_0100;
  localparam logic [31:0] I3 = 32'h8000_0180;
  localparam logic [31:0] I4 = 32'h8000_0200;
  localparam logic [31:0] D2 = 32'h8000_3000;
  localparam logic [31:0] D3 = 32'h8000_3004;
  localparam logic [31:0] I5 = 32'h8000_0500;
  localparam logic [31:0] W0 = 32'h2401_0005;
  localparam logic [31:0] W1 = 32'h0000_0013;
  localparam logic [31:0] W2 = 32'h1234_5678;
  localparam logic [31:0] W3 = 32'h3C1D_8000;
  localparam logic [31:0] W4 = 32'h55AA_55AA;
  localparam logic [31:0] SD = 32'hDEAD_BEEF;
  localparam logic [31:0] SC = 32'hCAFE_F00D;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 6'h0; flush = 1'b0;
    inst_req = 1'b0; inst_addr = Z;
    data_req = 1'b0; data_we = 1'b0; data_sel = 4'h0; data_addr = Z; data_wdata = Z;
    bus_rdata = Z; bus_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Fetch with three wait cycles
    vecs.push_back('{"reset",         7'b1000000, Z,  1'b0, 4'h0, Z,  Z,  Z,  5'b00000, 4'h0, Z,  Z,  Z,  Z});
    vecs.push_back('{"fetch_req",     7'b0000100, I0, 1'b0, 4'h0, Z,  Z,  Z,  5'b00010, 4'h0, Z,  Z,  Z,  Z});
    vecs.push_back('{"fetch_wait1",   7'b0000100, I0, 1'b0, 4'h0, Z,  Z,  Z,  5'b11010, 4'hF, I0, Z,  Z,  Z});
    vecs.push_back('{"fetch_wait2",   7'b0000100, I0, 1'b0, 4'h0, Z,  Z,  Z,  5'b11010, 4'hF, I0, Z,  Z,  Z});
    vecs.push_back('{"fetch_wait3",   7'b0000100, I0, 1'b0, 4'h0, Z,  Z,  Z,  5'b11010, 4'hF, I0, Z,  Z,  Z});
    vecs.push_back('{"fetch_ack",     7'b0000101, I0, 1'b0, 4'h0, Z,  Z,  W0, 5'b11000, 4'hF, I0, Z,  W0, Z});
    vecs.push_back('{"fetch_done",    7'b0000000, Z,  1'b0, 4'h0, Z,  Z,  Z,  5'b00000, 4'h0, I0, Z,  W0, Z});
    // Simultaneous store and fetch: store first, one idle cycle, then fetch
    vecs.push_back('{"simul_req",     7'b0000110, I1, 1'b1, 4'h3, D0, SD, Z,  5'b00011, 4'h0, I0, Z,  W0, Z});
    vecs.push_back('{"store_wait",    7'b0000110, I1, 1'b1, 4'h3, D0, SD, Z,  5'b11111, 4'h3, D0, SD, W0, Z});
    vecs.push_back('{"store_ack",     7'b0000111, I1, 1'b1, 4'h3, D0, SD, Z,  5'b11110, 4'h3, D0, SD, W0, Z});
    vecs.push_back('{"gap_idle",      7'b0000100, I1, 1'b0, 4'h0, Z,  Z,  Z,  5'b00010, 4'h0, D0, SD, W0, Z});
    vecs.push_back('{"fetch2_ack",    7'b0000101, I1, 1'b0, 4'h0, Z,  Z,  W1, 5'b11000, 4'hF, I1, Z,  W1, Z});
    // Load acked while MEM is held
    vecs.push_back('{"load_req",      7'b0000010, Z,  1'b0, 4'hF, D1, Z,  Z,  5'b00001, 4'h0, I1, Z,  W1, Z});
    vecs.push_back('{"load_ack_hold", 7'b0010011, Z,  1'b0, 4'hF, D1, Z,  W2, 5'b11010, 4'hF, D1, Z,  W1, W2});
    vecs.push_back('{"data_hold1",    7'b0010010, Z,  1'b0, 4'hF, D1, Z,  32'hAAAA_AAAA, 5'b00000, 4'h0, D1, Z, W1, W2});
    vecs.push_back('{"data_hold2",    7'b0010010, Z,  1'b0, 4'hF, D1, Z,  32'hAAAA_AAAA, 5'b00000, 4'h0, D1, Z, W1, W2});
    vecs.push_back('{"hold_release",  7'b0000010, Z,  1'b0, 4'hF, D1, Z,  Z,  5'b00000, 4'h0, D1, Z,  W1, W2});
    vecs.push_back('{"after_hold",    7'b0000000, Z,  1'b0, 4'h0, Z,  Z,  Z,  5'b00000, 4'h0, D1, Z,  W1, W2});
    // Flush during fetch: drain, discard, refetch
    vecs.push_back('{"fetch3_req",    7'b0000100, I2, 1'b0, 4'h0, Z,  Z,  Z,  5'b00010, 4'h0, D1, Z,  W1, W2});
    vecs.push_back('{"flush_busy",    7'b0100100, I2, 1'b0, 4'h0, Z,  Z,  Z,  5'b11000, 4'hF, I2, Z,  W1, W2});
    vecs.push_back('{"drain_wait",    7'b0000100, I3, 1'b0, 4'h0, Z,  Z,  Z,  5'b11010, 4'hF, I2, Z,  W1, W2});
    vecs.push_back('{"drain_ack",     7'b0000101, I3, 1'b0, 4'h0, Z,  Z,  32'hFFFF_FFFF, 5'b11010, 4'hF, I2, Z, W1, W2});
    vecs.push_back('{"refetch_req",   7'b0000100, I3, 1'b0, 4'h0, Z,  Z,  Z,  5'b00010, 4'h0, I2, Z,  W1, W2});
    vecs.push_back('{"refetch_ack",   7'b0000101, I3, 1'b0, 4'h0, Z,  Z,  W3, 5'b11000, 4'hF, I3, Z,  W3, W2});
    vecs.push_back('{"refetch_done",  7'b0000000, Z,  1'b0, 4'h0, Z,  Z,  Z,  5'b00000, 4'h0, I3, Z,  W3, W2});
    // Flush coinciding with the fetch ack
    vecs.push_back('{"fetch4_req",    7'b0000100, I4, 1'b0, 4'h0, Z,  Z,  Z,  5'b00010, 4'h0, I3, Z,  W3, W2});
    vecs.push_back('{"flush_ack",     7'b0100101, I4, 1'b0, 4'h0, Z,  Z,  32'h1111_1111, 5'b11000, 4'hF, I4, Z, W3, W2});
    vecs.push_back('{"flush_ack_end", 7'b0000000, Z,  1'b0, 4'h0, Z,  Z,  Z,  5'b00000, 4'h0, I4, Z,  W3, W2});
    // Reset in the middle of a store
    vecs.push_back('{"store2_req",    7'b0000010, Z,  1'b1, 4'hF, D2, SC, Z,  5'b00001, 4'h0, I4, Z,  W3, W2});
    vecs.push_back('{"rst_busy",      7'b1000010, Z,  1'b1, 4'hF, D2, SC, Z,  5'b11111, 4'hF, D2, SC, W3, W2});
    vecs.push_back('{"post_rst",      7'b0000110, I5, 1'b0, 4'hF, D3, Z,  Z,  5'b00011, 4'h0, Z,  Z,  Z,  Z});
    vecs.push_back('{"load2_wait",    7'b0000110, I5, 1'b0, 4'hF, D3, Z,  Z,  5'b11011, 4'hF, D3, Z,  Z,  Z});
    vecs.push_back('{"load2_ack",     7'b0000111, I5, 1'b0, 4'hF, D3, Z,  W4, 5'b11010, 4'hF, D3, Z,  Z,  W4});
    vecs.push_back('{"load2_done",    7'b0000000, Z,  1'b0, 4'h0, Z,  Z,  Z,  5'b00000, 4'h0, D3, Z,  Z,  W4});

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst        = vecs[i].ctl[6];
      flush      = vecs[i].ctl[5];
      stall      = {1'b0, vecs[i].ctl[4], 2'b00, vecs[i].ctl[3], 1'b0};
      inst_req   = vecs[i].ctl[2];
      data_req   = vecs[i].ctl[1];
      bus_ack    = vecs[i].ctl[0];
      inst_addr  = vecs[i].iaddr;
      data_we    = vecs[i].dwe;
      data_sel   = vecs[i].dsel;
      data_addr  = vecs[i].daddr;
      data_wdata = vecs[i].dwdata;
      bus_rdata  = vecs[i].brdata;
      #1;
      $display("vec %0d %s cyc=%b stb=%b we=%b sel=%h addr=%h istall=%b dstall=%b irdata=%h drdata=%h",
               i, vecs[i].name, bus_cyc, bus_stb, bus_we, bus_sel, bus_addr,
               inst_stallreq, data_stallreq, inst_rdata, data_rdata);
      chk({vecs[i].name, ".bus_cyc"},       32'(bus_cyc),       32'(vecs[i].eflags[4]));
      chk({vecs[i].name, ".bus_stb"},       32'(bus_stb),       32'(vecs[i].eflags[3]));
      chk({vecs[i].name, ".bus_we"},        32'(bus_we),        32'(vecs[i].eflags[2]));
      chk({vecs[i].name, ".inst_stallreq"}, 32'(inst_stallreq), 32'(vecs[i].eflags[1]));
      chk({vecs[i].name, ".data_stallreq"}, 32'(data_stallreq), 32'(vecs[i].eflags[0]));
      chk({vecs[i].name, ".bus_sel"},       32'(bus_sel),       32'(vecs[i].esel));
      chk({vecs[i].name, ".bus_addr"},      bus_addr,           vecs[i].eaddr);
      chk({vecs[i].name, ".bus_wdata"},     bus_wdata,          vecs[i].ewdata);
      chk({vecs[i].name, ".inst_rdata"},    inst_rdata,         vecs[i].eirdata);
      chk({vecs[i].name, ".data_rdata"},    data_rdata,         vecs[i].edrdata);
      chk({vecs[i].name, ".bus_timeout"},   32'(bus_timeout),   32'h0);
    end

    // Fetch acked while IF is held: INST_HOLD keeps the word and releases the stall
    @(negedge clk);
    idle_inputs();
    inst_req = 1'b1; inst_addr = 32'h8000_0300;
    #1;
    $display("hold_fetch req istall=%b", inst_stallreq);
    chk("ihold.req_stall", 32'(inst_stallreq), 32'h1);
    @(negedge clk);
    stall = 6'b000010; bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    #1;
    $display("hold_fetch ack irdata=%h istall=%b", inst_rdata, inst_stallreq);
    chk("ihold.ack_rdata", inst_rdata, 32'h0BAD_F00D);
    chk("ihold.ack_stall", 32'(inst_stallreq), 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = 32'h7777_7777;
      stall = (k == 0) ? 6'b000010 : 6'b000000;
      #1;
      $display("hold_fetch hold%0d cyc=%b irdata=%h istall=%b", k, bus_cyc, inst_rdata, inst_stallreq);
      chk("ihold.hold_cyc", 32'(bus_cyc), 32'h0);
      chk("ihold.hold_rdata", inst_rdata, 32'h0BAD_F00D);
      chk("ihold.hold_stall", 32'(inst_stallreq), 32'h0);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    $display("hold_fetch done cyc=%b irdata=%h", bus_cyc, inst_rdata);
    chk("ihold.done_cyc", 32'(bus_cyc), 32'h0);
    chk("ihold.done_rdata", inst_rdata, 32'h0BAD_F00D);

`ifdef BUS_TIMEOUT_EN
    // Fetch with no ack: aborted in its fourth busy cycle
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h8000_0400;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (inst_stallreq && n < 10);
    $display("timeout hit after %0d busy cycles irdata=%h cyc=%b", n, inst_rdata, bus_cyc);
    chk("tmo.busy_cycles", 32'(n), 32'd4);
    chk("tmo.stallreq", 32'(inst_stallreq), 32'h0);
    chk("tmo.rdata", inst_rdata, 32'h0);
    chk("tmo.cyc_last", 32'(bus_cyc), 32'h1);
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    $display("timeout pulse cyc=%b stb=%b timeout=%b irdata=%h", bus_cyc, bus_stb, bus_timeout, inst_rdata);
    chk("tmo.cyc_drop", 32'(bus_cyc), 32'h0);
    chk("tmo.stb_drop", 32'(bus_stb), 32'h0);
    chk("tmo.pulse", 32'(bus_timeout), 32'h1);
    chk("tmo.rdata_reg", inst_rdata, 32'h0);
    @(negedge clk);
    #1;
    $display("timeout after pulse timeout=%b", bus_timeout);
    chk("tmo.pulse_end", 32'(bus_timeout), 32'h0);
`else
    n = 0;
    @(negedge clk);
    #1;
    chk("notmo.timeout_low", 32'(bus_timeout), 32'(n));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
